// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states and
// small decode helpers used by datamem_responder and mem_load_extend.
package datamem_pkg;

  localparam int DEFAULT_DEPTH_BYTES = 128;
  localparam int ADDR_BITS           = $clog2(DEFAULT_DEPTH_BYTES);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int addr_bits_for(input int depth_bytes);
    return $clog2(depth_bytes);
  endfunction

  function automatic logic funct3_illegal(input logic wr, input logic [2:0] f3);
    if (wr) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == 2'b01) && addr_lo[0]) || ((size == 2'b10) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational load formatter: assembles the four little-endian byte lanes of an
// access and applies the funct3 sign/zero extension. Illegal codes yield zero.
module mem_load_extend
  import datamem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] lanes,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (funct3)
      F3_LB:   rdata = {{24{lanes[7]}}, lanes[7:0]};
      F3_LH:   rdata = {{16{lanes[15]}}, lanes[15:0]};
      F3_LW:   rdata = lanes;
      F3_LBU:  rdata = {24'd0, lanes[7:0]};
      F3_LHU:  rdata = {16'd0, lanes[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/datamem_responder.sv
// Data-memory responder: valid/ready load/store port onto a byte-addressed
// little-endian RAM with LATENCY-cycle response. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int            AW          = addr_bits_for(DEPTH_BYTES);
  localparam int            CW          = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam bit            DIRECT_RESP = (LATENCY == 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          in_idle;
  logic [AW-1:0] acc_addr;
  logic          acc_wr;
  logic [2:0]    acc_funct3;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [3:0]    acc_be;
  logic [31:0]   raw_lanes;
  logic [31:0]   load_data;
  logic          enter_resp;
  logic          mem_we;
  logic          unused_addr_hi;

  // With LATENCY 1 the RAM is touched on the accept edge itself, so the live
  // request is used; otherwise the captured copy is.
  assign in_idle    = (state_q == IDLE);
  assign acc_addr   = in_idle ? req_addr[AW-1:0] : addr_q;
  assign acc_wr     = in_idle ? req_wr           : wr_q;
  assign acc_funct3 = in_idle ? req_funct3       : funct3_q;
  assign acc_wdata  = in_idle ? req_wdata        : wdata_q;
  assign acc_be     = byte_enables(acc_funct3[1:0]);

  assign unused_addr_hi = ^req_addr[31:AW];

`ifdef MISALIGN_TRAP_EN
  assign acc_err = funct3_illegal(acc_wr, acc_funct3) ||
                   misaligned(acc_funct3[1:0], acc_addr[1:0]);
`else
  assign acc_err = funct3_illegal(acc_wr, acc_funct3);
`endif

  always_comb begin
    raw_lanes = '0;
    for (int i = 0; i < 4; i++) begin
      raw_lanes[8*i +: 8] = mem[acc_addr + AW'(i)];
    end
  end

  mem_load_extend u_load_extend (
    .funct3 (acc_funct3),
    .lanes  (raw_lanes),
    .rdata  (load_data)
  );

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[AW-1:0];
          wr_d     = req_wr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          if (DIRECT_RESP) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_wr || acc_err) ? '0 : load_data;
    end
  end

  assign mem_we = enter_resp && acc_wr && !acc_err;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the RAM array has no reset; only the write is blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_addr + AW'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = in_idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: two instances (LATENCY 1 and 3) share one request
// stream and are checked against a byte-array reference model.
module tb_datamem_responder;

  localparam int DEPTH = 128;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;

  always #5 clk = ~clk;

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_wr(req_wr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_wr(req_wr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  int          n_tests;
  int          n_fail;
  logic [7:0]  mmem [2][DEPTH];
  logic [31:0] rd;
  logic        er;
  logic [31:0] old_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: applies one transaction to instance d's memory image.
  task automatic model_txn(input int d, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata);
    int     nbytes;
    bit     legal, mis;
    longint val;
    nbytes = 1 << f3[1:0];
    if (wr) legal = f3 inside {3'd0, 3'd1, 3'd2};
    else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    mis   = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
    err   = !legal || (TRAP && mis);
    rdata = '0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < nbytes; i++)
        mmem[d][int'((addr + 32'(i)) % DEPTH)] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < nbytes; i++)
        val += longint'(mmem[d][int'((addr + 32'(i)) % DEPTH)]) << (8 * i);
      if (!f3[2] && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
        val -= (longint'(1) << (8 * nbytes));
      rdata = val[31:0];
    end
  endtask

  // One transaction through both instances; hold>0 keeps rsp_ready low that many
  // cycles once the slower instance responds.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] rd_b, output logic err_b);
    logic [31:0] exp_rd [2];
    logic        exp_err [2];
    int          ph [2];
    int          lat_exp [2];
    logic        v [2], r [2], e [2];
    logic [31:0] dd [2];
    int          hold_left;
    lat_exp[0] = LAT_A;
    lat_exp[1] = LAT_B;
    rd_b  = '0;
    err_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_txn(d, wr, f3, addr, wdata, exp_err[d], exp_rd[d]);
      ph[d] = 0;
    end
    @(negedge clk);
    check("idle_ready_a", req_ready_a, 1);
    check("idle_ready_b", req_ready_b, 1);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = (hold == 0);
    hold_left  = hold;
    for (int k = 1; k <= 40 && !(ph[0] == 3 && ph[1] == 3); k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_wr     = 1'($urandom);
      end
      v[0] = rsp_valid_a; r[0] = req_ready_a; e[0] = rsp_err_a; dd[0] = rsp_rdata_a;
      v[1] = rsp_valid_b; r[1] = req_ready_b; e[1] = rsp_err_b; dd[1] = rsp_rdata_b;
      for (int d = 0; d < 2; d++) begin
        case (ph[d])
          0: begin
            if (v[d]) begin
              check(d == 0 ? "lat_a" : "lat_b", k, lat_exp[d]);
              check(d == 0 ? "rdata_a" : "rdata_b", dd[d], exp_rd[d]);
              check(d == 0 ? "err_a" : "err_b", e[d], exp_err[d]);
              check(d == 0 ? "resp_ready_a" : "resp_ready_b", r[d], 0);
              if (d == 1) begin rd_b = dd[d]; err_b = e[d]; end
              ph[d] = 1;
            end else begin
              check(d == 0 ? "busy_ready_a" : "busy_ready_b", r[d], 0);
            end
          end
          1: begin
            check(d == 0 ? "held_valid_a" : "held_valid_b", v[d], 1);
            check(d == 0 ? "held_rdata_a" : "held_rdata_b", dd[d], exp_rd[d]);
            check(d == 0 ? "held_ready_a" : "held_ready_b", r[d], 0);
          end
          2: begin
            check(d == 0 ? "retired_valid_a" : "retired_valid_b", v[d], 0);
            check(d == 0 ? "retired_ready_a" : "retired_ready_b", r[d], 1);
            ph[d] = 3;
          end
          default: ;
        endcase
      end
      if (hold > 0 && ph[1] >= 1 && !rsp_ready) begin
        hold_left--;
        if (hold_left == 0) rsp_ready = 1'b1;
      end
      for (int d = 0; d < 2; d++)
        if (ph[d] == 1 && rsp_ready) ph[d] = 2;
    end
    if (!(ph[0] == 3 && ph[1] == 3)) check("txn_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_rst_valid_a", rsp_valid_a, 0);
    check("in_rst_valid_b", rsp_valid_b, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_a", req_ready_a, 1);
    check("rst_ready_b", req_ready_b, 1);
    check("rst_valid_b", rsp_valid_b, 0);
    check("rst_rdata_b", rsp_rdata_b, 0);
    check("rst_err_b", rsp_err_b, 0);
    check("rst_rdata_a", rsp_rdata_a, 0);

    for (int w = 0; w < DEPTH / 4; w++)
      run_txn(1'b1, 3'b010, 32'(4 * w), $urandom, 0, rd, er);

    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw_err", er, 0);
    check("sw_rdata", rd, 0);
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, 4, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    check("lw_err", er, 0);
    run_txn(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
    check("lb_13", rd, 32'hFFFFFFDE);
    run_txn(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er);
    check("lbu_13", rd, 32'h000000DE);
    run_txn(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
    check("lh_12", rd, 32'hFFFFDEAD);

    run_txn(1'b1, 3'b010, 32'h7E, 32'h11223344, 0, rd, er);
    check("wrap_sw_err", er, TRAP);
    run_txn(1'b0, 3'b100, 32'h7E, 32'h0, 0, rd, er);
    run_txn(1'b0, 3'b100, 32'h7F, 32'h0, 0, rd, er);
    run_txn(1'b0, 3'b100, 32'h00, 32'h0, 0, rd, er);
    run_txn(1'b0, 3'b100, 32'h01, 32'h0, 0, rd, er);

    run_txn(1'b0, 3'b011, 32'h20, 32'h0, 0, rd, er);
    check("ill_load_err", er, 1);
    check("ill_load_rdata", rd, 0);
    run_txn(1'b1, 3'b011, 32'h20, 32'hCAFEF00D, 0, rd, er);
    check("ill_store_err", er, 1);
    run_txn(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);

    // Store interrupted by reset: dut_a commits on its accept edge, dut_b is still waiting.
    old_word = {mmem[1][8'h43], mmem[1][8'h42], mmem[1][8'h41], mmem[1][8'h40]};
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = ~old_word; rsp_ready = 1'b1;
    model_txn(0, 1'b1, 3'b010, 32'h40, ~old_word, er, rd);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_wait_valid_b", rsp_valid_b, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid_a", rsp_valid_a, 0);
    check("mid_rst_valid_b", rsp_valid_b, 0);
    check("mid_rst_rdata_b", rsp_rdata_b, 0);
    check("mid_rst_err_b", rsp_err_b, 0);
    @(negedge clk);
    check("post_rst_ready_b", req_ready_b, 1);
    run_txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er);
    check("rst_no_commit", rd, old_word);

    for (int n = 0; n < 150; n++)
      run_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
              ($urandom_range(0, 9) == 0) ? 4 : 0, rd, er);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
